// File: rtl/snn_noc_pkg.sv
// snn_noc_pkg: shared defaults, index-width helper and event/FSM types for the
// spike event arbiter.
package snn_noc_pkg;

  localparam int ADDR_WIDTH_DEF  = 12;
  localparam int NUM_NEURONS_DEF = 10;

  // Width of a neuron index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_NEURONS_DEF);

  // One outgoing spike event: source address plus neuron index.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] source;
    logic [IDX_W_DEF-1:0]      index;
  } spike_event_t;

  // Output register state: nothing presented, or an event held until accepted.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/spike_event_arbiter_if.sv
// spike_event_arbiter_if: valid/ready event port between the arbiter (master)
// and the network interface (slave).
interface spike_event_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int IDX_W      = 4
);
  logic                  event_valid;
  logic                  event_ready;
  logic [ADDR_WIDTH-1:0] event_source;
  logic [IDX_W-1:0]      event_index;

  modport master (
    output event_valid,
    output event_source,
    output event_index,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_source,
    input  event_index,
    output event_ready
  );
endinterface

// File: rtl/spike_event_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending neuron at or
// after the pointer, wrapping past the last neuron.
module rr_arbiter #(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_NEURONS-1:0] i_pending,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  output logic [IDX_W-1:0]       o_grant,
  output logic                   o_any_pending
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip the assignment infer a latch.
    o_grant = '0;
    for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
      int w_j;
      w_j = int'(i_rr_ptr) + k;
      if (w_j >= NUM_NEURONS) w_j -= NUM_NEURONS;
      if (i_pending[IDX_W'(w_j)]) o_grant = IDX_W'(w_j);
    end
  end

  assign o_any_pending = |i_pending;

endmodule

// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter: captures spike rising edges into a pending bitmap and
// streams one source address per cycle, round-robin, over a valid/ready port.
// Optional feature macro: SPIKE_OVERRUN_COUNT_EN adds the overrun_count port
// that counts edges dropped because the neuron was already pending.
module spike_event_arbiter
  import snn_noc_pkg::*;
#(
  parameter  int NUM_NEURONS  = 10,
  parameter  int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter  int BASE_ADDRESS = 0,
  parameter  int COUNT_W      = 16,
  localparam int IDX_W        = idx_w(NUM_NEURONS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spike_in,
  spike_event_arbiter_if.master  ev,
  output logic [COUNT_W-1:0]     event_count,
  output logic                   idle
`ifdef SPIKE_OVERRUN_COUNT_EN
  ,
  output logic [COUNT_W-1:0]     overrun_count
`endif
);

  logic [NUM_NEURONS-1:0] r_spike_prev;
  logic [NUM_NEURONS-1:0] r_pending;
  logic [IDX_W-1:0]       r_rr_ptr;
  out_state_t             r_state;
  logic [ADDR_WIDTH-1:0]  r_source;
  logic [IDX_W-1:0]       r_index;
  logic [COUNT_W-1:0]     r_event_count;

  logic [NUM_NEURONS-1:0] w_edge;
  logic [NUM_NEURONS-1:0] w_grant_mask;
  logic [NUM_NEURONS-1:0] w_pending_nxt;
  logic [IDX_W-1:0]       w_grant;
  logic [IDX_W-1:0]       w_ptr_nxt;
  logic                   w_any_pending;
  logic                   w_load;
  logic                   w_take;
  logic                   w_handshake;

  rr_arbiter #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .i_pending     (r_pending),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant       (w_grant),
    .o_any_pending (w_any_pending)
  );

  assign w_edge        = spike_in & ~r_spike_prev;
  assign w_load        = (r_state == ST_EMPTY) || ev.event_ready;
  assign w_take        = w_load && w_any_pending;
  assign w_grant_mask  = w_take ? (NUM_NEURONS'(1) << w_grant) : '0;
  // A new edge on the bit being granted re-sets it: the set wins over the clear.
  assign w_pending_nxt = (r_pending & ~w_grant_mask) | w_edge;
  assign w_ptr_nxt     = (w_grant == IDX_W'(NUM_NEURONS - 1)) ? '0 : w_grant + 1'b1;
  assign w_handshake   = (r_state == ST_HOLD) && ev.event_ready;

  // Edge history, pending bitmap and round-robin pointer.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (RESET) begin
      r_spike_prev <= '0;
      r_pending    <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_spike_prev <= spike_in;
      if (clear) begin
        r_pending <= '0;
        r_rr_ptr  <= '0;
      end else begin
        r_pending <= w_pending_nxt;
        if (w_take) r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Output FSM with the registered event; held stable while downstream stalls.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_EMPTY;
      r_source <= '0;
      r_index  <= '0;
    end else if (clear) begin
      r_state <= ST_EMPTY;
    end else if (w_load) begin
      if (w_any_pending) begin
        r_state  <= ST_HOLD;
        r_source <= ADDR_WIDTH'(BASE_ADDRESS + int'(w_grant));
        r_index  <= w_grant;
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

  // Saturating count of events accepted downstream this timestep.
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      r_event_count <= '0;
    end else if (w_handshake && (r_event_count != '1)) begin
      r_event_count <= r_event_count + 1'b1;
    end
  end

`ifdef SPIKE_OVERRUN_COUNT_EN
  localparam int CW1 = COUNT_W + 1;

  logic [COUNT_W-1:0]     r_overrun_count;
  logic [NUM_NEURONS-1:0] w_overrun;
  logic [COUNT_W:0]       w_ov_sum;

  // Edges on an already-pending bit that is not being granted are lost.
  assign w_overrun = w_edge & r_pending & ~w_grant_mask;

  // Current count plus the number of edges lost this cycle, one bit wider.
  always_comb begin
    w_ov_sum = {1'b0, r_overrun_count};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_ov_sum = w_ov_sum + CW1'(w_overrun[i]);
    end
  end

  // Saturating overrun counter.
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      r_overrun_count <= '0;
    end else if (w_ov_sum[COUNT_W]) begin
      r_overrun_count <= '1;
    end else begin
      r_overrun_count <= w_ov_sum[COUNT_W-1:0];
    end
  end

  assign overrun_count = r_overrun_count;
`endif

  assign ev.event_valid  = (r_state == ST_HOLD);
  assign ev.event_source = r_source;
  assign ev.event_index  = r_index;
  assign event_count     = r_event_count;
  assign idle            = !w_any_pending && (r_state == ST_EMPTY);

endmodule

// File: tb/tb_spike_event_arbiter.sv
// tb_spike_event_arbiter: directed scenarios plus randomized spikes, checked
// by a transaction-level reference model feeding a scoreboard queue.
module tb_spike_event_arbiter;
  import snn_noc_pkg::*;

  localparam int N       = 10;
  localparam int AW      = 12;
  localparam int BASE    = 0;
  localparam int CW      = 16;
  localparam int IW      = idx_w(N);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [N-1:0]  spike;
  logic [CW-1:0] event_count;
  logic          idle;
`ifdef SPIKE_OVERRUN_COUNT_EN
  logic [CW-1:0] overrun_count;
`endif

  spike_event_arbiter_if #(.ADDR_WIDTH(AW), .IDX_W(IW)) ev_if ();

  spike_event_arbiter #(
    .NUM_NEURONS  (N),
    .ADDR_WIDTH   (AW),
    .BASE_ADDRESS (BASE),
    .COUNT_W      (CW)
  ) dut (
    .CLK           (clk),
    .RESET         (rst),
    .clear         (clear),
    .spike_in      (spike),
    .ev            (ev_if),
    .event_count   (event_count),
    .idle          (idle)
`ifdef SPIKE_OVERRUN_COUNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [N-1:0]   m_pend;
  bit [N-1:0]   m_prev;
  int           m_ptr;
  bit           m_full;
  int           m_count;
  int           m_ov;
  spike_event_t exp_q[$];
  int           seen[$];

  // Effect of the coming rising edge, computed from the behavioural rules.
  task automatic model_step();
    bit [N-1:0] edges;
    int g;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_ptr = 0; m_full = 0; m_count = 0; m_ov = 0;
      exp_q.delete();
      return;
    end
    if (clear) begin
      if (m_full && exp_q.size() > 0) void'(exp_q.pop_front());
      m_pend = '0; m_ptr = 0; m_full = 0; m_count = 0; m_ov = 0;
      m_prev = spike;
      return;
    end
    edges = spike & ~m_prev;
    if (m_full && ev_if.event_ready && m_count < CNT_MAX) m_count++;
    if (!m_full || ev_if.event_ready) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && m_pend[j]) g = j;
      end
      if (g >= 0) begin
        spike_event_t e;
        m_pend[g] = 1'b0;
        m_ptr     = (g + 1) % N;
        m_full    = 1'b1;
        e.source  = AW'(BASE + g);
        e.index   = IW'(g);
        exp_q.push_back(e);
      end else begin
        m_full = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (edges[i]) begin
        if (m_pend[i]) begin
          if (m_ov < CNT_MAX) m_ov++;
        end else begin
          m_pend[i] = 1'b1;
        end
      end
    end
    m_prev = spike;
  endtask

  always @(negedge clk) begin
    #1;
    model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", ev_if.event_valid, m_full);
      check("idle", idle, (m_pend == '0) && !m_full);
      check("event_count", event_count, m_count);
`ifdef SPIKE_OVERRUN_COUNT_EN
      check("overrun_count", overrun_count, m_ov);
`endif
      if (ev_if.event_valid && ev_if.event_ready && !clear) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got index %0d expected no event", ev_if.event_index);
        end else begin
          spike_event_t e;
          e = exp_q.pop_front();
          check("sb_source", ev_if.event_source, e.source);
          check("sb_index", ev_if.event_index, e.index);
        end
        seen.push_back(int'(ev_if.event_index));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && !idle; i++) tick(1);
    check(name, idle, 1'b1);
  endtask

  function automatic int seen_at(input int i);
    return (seen.size() > i) ? seen[i] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; spike = '0; ev_if.event_ready = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state.
    check("rst_valid", ev_if.event_valid, 0);
    check("rst_source", ev_if.event_source, 0);
    check("rst_index", ev_if.event_index, 0);
    check("rst_count", event_count, 0);
    check("rst_idle", idle, 1);
`ifdef SPIKE_OVERRUN_COUNT_EN
    check("rst_overrun", overrun_count, 0);
`endif

    // Single spike on neuron 0.
    ev_if.event_ready = 1'b1;
    seen.delete();
    spike = N'(1);
    tick(1);
    spike = '0;
    wait_idle("s1_idle", 20);
    check("s1_count", event_count, 1);
    check("s1_n", seen.size(), 1);
    check("s1_e0", seen_at(0), 0);

    // Round-robin order 3, 5, 7.
    do_clear();
    seen.delete();
    spike = N'((1 << 3) | (1 << 5) | (1 << 7));
    tick(1);
    spike = '0;
    wait_idle("s2_idle", 20);
    check("s2_count", event_count, 3);
    check("s2_n", seen.size(), 3);
    check("s2_e0", seen_at(0), 3);
    check("s2_e1", seen_at(1), 5);
    check("s2_e2", seen_at(2), 7);

    // Wrap: pointer parked at 8, then 1 and 9 pending.
    do_clear();
    spike = N'(1 << 7);
    tick(1);
    spike = '0;
    wait_idle("s3_park", 20);
    seen.delete();
    spike = N'((1 << 1) | (1 << 9));
    tick(1);
    spike = '0;
    wait_idle("s3_idle", 20);
    check("s3_n", seen.size(), 2);
    check("s3_e0", seen_at(0), 9);
    check("s3_e1", seen_at(1), 1);

    // Backpressure and overrun on neuron 2.
    do_clear();
    seen.delete();
    ev_if.event_ready = 1'b0;
    spike = N'(1 << 2);
    tick(1);
    spike = '0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("s4_hold_valid", ev_if.event_valid, 1);
      check("s4_hold_source", ev_if.event_source, BASE + 2);
      tick(1);
    end
    spike = N'(1 << 2); tick(1); spike = '0; tick(1);
    spike = N'(1 << 2); tick(1); spike = '0; tick(1);
    check("s4_still_source", ev_if.event_source, BASE + 2);
`ifdef SPIKE_OVERRUN_COUNT_EN
    check("s4_overrun", overrun_count, 1);
`endif
    ev_if.event_ready = 1'b1;
    wait_idle("s4_idle", 20);
    check("s4_n", seen.size(), 2);
    check("s4_e0", seen_at(0), 2);
    check("s4_e1", seen_at(1), 2);
    check("s4_count", event_count, 2);

    // Clear after three handshakes of a full burst.
    do_clear();
    seen.delete();
    spike = '1;
    tick(1);
    spike = '0;
    for (int i = 0; i < 50 && seen.size() < 3; i++) tick(1);
    check("s5_three", seen.size(), 3);
    do_clear();
    check("s5_valid", ev_if.event_valid, 0);
    check("s5_count", event_count, 0);
    check("s5_idle", idle, 1);
    seen.delete();
    spike = N'((1 << 8) | (1 << 9));
    tick(1);
    spike = '0;
    wait_idle("s5_idle2", 20);
    check("s5_n", seen.size(), 2);
    check("s5_e0", seen_at(0), 8);
    check("s5_e1", seen_at(1), 9);

    // Level spike on neuron 4.
    do_clear();
    seen.delete();
    spike = N'(1 << 4);
    tick(10);
    spike = '0;
    wait_idle("s6_idle", 20);
    check("s6_n", seen.size(), 1);
    check("s6_e0", seen_at(0), 4);

    // Randomized traffic with occasional clear and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      spike             = spike ^ N'($urandom & $urandom);
      ev_if.event_ready = ($urandom_range(3) != 0);
      clear             = ($urandom_range(99) == 0);
      rst               = (c == 1500 || c == 1501);
      tick(1);
    end
    rst = 1'b0; clear = 1'b0; spike = '0; ev_if.event_ready = 1'b1;
    wait_idle("rand_drain", 50);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_event_arbiter.md
# spike_event_arbiter

- Sits directly upstream of the network interface.
- Captures spike pulses from the local neuron array into a pending bitmap.
- Selects one pending neuron per cycle in round-robin order and presents its source address on a valid/ready port.
- Replaces the combinational, lock-guarded spike fan-in with a clocked, lossless-per-timestep event stream.

## Interface
- NUM_NEURONS, 10: neurons served.
- ADDR_WIDTH, 12: neuron address width.
- BASE_ADDRESS, 0: address of neuron 0; neuron i has address BASE_ADDRESS+i.
- COUNT_W, 16: event/overrun counter width.
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- clear  in  1  synchronous timestep clear, active-high.
- spike_in  in  NUM_NEURONS  spike levels, bit i = neuron i.
- event_ready  in  1  downstream accepts event.
- event_valid  out  1  event present.
- event_source  out  ADDR_WIDTH  source neuron address.
- event_index  out  IDX_W  source neuron index; IDX_W = clog2(NUM_NEURONS).
- event_count  out  COUNT_W  events handed off this timestep.
- idle  out  1  no pending bits and event_valid low.
- overrun_count  out  COUNT_W  spikes dropped this timestep (only with the macro).

## Operation
- **Edge detect:** spike_prev registers spike_in every cycle, including during clear. A rising edge is spike_in[i] & ~spike_prev[i].
- **Pending set:** an edge sets pending[i].
- **Overrun:** an edge while pending[i] is already 1 is an overrun. It is dropped, because the bit stays set.
- **Output FSM, two states:**
  - EMPTY: event_valid = 0.
  - HOLD: event_valid = 1.
  - EMPTY → HOLD when any pending bit is set.
  - HOLD → HOLD (reload) when event_ready is high and pending is non-empty.
  - HOLD → EMPTY when event_ready is high and pending is empty.
  - HOLD holds all outputs stable while event_ready is low.
- **Load:** a load occurs in EMPTY, or in HOLD with event_ready high.
  - Grant = first set pending index searching from rr_ptr upward, with wrap.
  - The output register takes that index and BASE_ADDRESS+index, truncated to ADDR_WIDTH.
  - pending[grant] clears.
  - rr_ptr becomes grant+1, wrapping from NUM_NEURONS-1 to 0.
- **Same-cycle grant and edge on the same bit:** the set wins, so pending stays 1. This does not count as an overrun.
- **event_count:** increments on each handshake (event_valid & event_ready) and saturates at all-ones.
- **clear = 1:**
  - pending is zeroed, event_valid goes to 0, and the FSM goes to EMPTY.
  - rr_ptr, event_count and overrun_count go to 0.
  - Edges sampled in that cycle are discarded.
  - A handshake in the clear cycle is not counted.
- **Priority:** RESET > clear > normal operation.

## Timing
- **Reset values:** event_valid 0, event_source 0, event_index 0, event_count 0, overrun_count 0, idle 1. pending, spike_prev and rr_ptr are also 0.
- **Latency:** with an empty output register and no competition, an edge sampled at clock k gives pending at k and event_valid high after clock k+1.
- **Throughput:** one event per cycle while event_ready is held high.
- **Empty point:** idle asserts the cycle after the last handshake empties the block.
- **Fairness:** starvation-free; any pending neuron is granted within NUM_NEURONS loads.
- **RESET or clear mid-handshake:** the in-flight event is discarded and not counted.

## Configuration
- **SPIKE_OVERRUN_COUNT_EN defined:**
  - overrun_count is present.
  - It increments once per dropped edge, saturates, and is zeroed by clear and RESET.
- **SPIKE_OVERRUN_COUNT_EN undefined:**
  - The port and counter are absent.
  - Overruns are still dropped silently.

## Structure
- **Package snn_noc_pkg:** holds the ADDR_WIDTH default, a clog2-based IDX_W helper, and a spike_event_t typedef (source address plus index).
- **Sub-module rr_arbiter:**
  - Inputs: pending vector and rr_ptr.
  - Outputs: grant index and any_pending.
  - Purely combinational.
- The top level holds the edge detect, pending, FSM, counters and output register.

## Test plan
- **Single spike:** RESET, then a 1-cycle pulse on neuron 0 with event_ready=1 → event_valid is high exactly one cycle, 2 clocks after the pulse edge, with event_source=0 and event_count=1.
- **Round-robin order:** neurons 3, 5 and 7 pulse in the same cycle with event_ready=1 → events 3, 5, 7 on consecutive cycles, then idle=1 and event_count=3.
- **Wrap and fairness:** rr_ptr=8 with neurons 1 and 9 pending → order is 9 then 1.
- **Backpressure and overrun:**
  - Neuron 2 pulses while event_ready=0.
  - Output holds source 2 for 5 cycles.
  - A second neuron-2 pulse during the hold re-pends it.
  - A third pulse before it is granted → overrun_count=1 with the macro; exactly two events emitted.
- **Clear mid-operation:** neurons 0–9 pulse together, then clear is asserted after 3 handshakes → event_valid=0, event_count=0 and idle=1 the next cycle; subsequent pulses on 8 and 9 emit 8 then 9.
- **Level spike:** spike_in[4] held high for 10 cycles → exactly one event, source 4.
